c1541_track_sched: RTL and testbench

- Head-position and track-buffer scheduler for one 1541 drive, in the clk_c1541 domain, between c1541_logic (stepper phases, motor, activity) and the SD-backed track buffer loader.
- Decodes stepper phase changes into a half-track position and waits for the head to settle before acting.
- Sequences the buffer: flush the dirty old track, then load the new one.
- Tells the GCR engine when the buffer matches the head position.

---
 rtl/c1541_track_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_c1541_track_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_track_sched.sv
// c1541_track_sched: head-position tracker and track-buffer scheduler for one
// 1541 drive in the clk_c1541 domain. Decodes stepper phases into a half-track
// position, waits for the head to settle, then flushes a dirty buffer and loads
// the track under the head.
// Optional: define C1541_ACT_FLUSH_EN to flush dirty data on the falling edge of
// the activity LED while idle (no reload, buffer stays ready).
module c1541_track_sched #(
    parameter int SETTLE_CYC = 32000,
    parameter int RESET_HALF = 36,
    parameter int MIN_HALF   = 1,
    parameter int MAX_HALF   = 80
) (
    input  logic       clk_c1541,
    input  logic       reset,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       act,
    input  logic       buff_we,
    input  logic       disk_change,
    input  logic       busy,
    output logic [5:0] track,
    output logic [6:0] half_track,
    output logic       tr00_sense_n,
    output logic       save_req,
    output logic       load_req,
    output logic       ready,
    output logic       dirty
);

`ifdef C1541_ACT_FLUSH_EN
    localparam bit ACT_FLUSH = 1'b1;
`else
    localparam bit ACT_FLUSH = 1'b0;
`endif

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [6:0]       MIN_H     = 7'(MIN_HALF);
    localparam logic [6:0]       MAX_H     = 7'(MAX_HALF);
    localparam logic [6:0]       RST_H     = 7'(RESET_HALF);
    localparam logic [5:0]       RST_TRACK = 6'(RESET_HALF / 2);

    typedef enum logic [2:0] {
        IDLE, SETTLE, SAVE, SAVE_WAIT, LOAD, LOAD_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       stp_r;
    logic [1:0]       stp_up, stp_dn;
    logic             act_r, dc_r;
    logic             step_inc, step_dec, step;
    logic             act_fall, dc_fall;
    logic             loaded_valid;
    logic             dc_seen;
    logic             act_flush, flush_moved;
    logic             cnt_clr, latch_track, set_valid, save_acc;
    logic             flush_start, flush_end;

    // One half-track move with saturation at the mechanical stops.
    function automatic logic [6:0] sat_step(input logic [6:0] h, input logic inc);
        if (inc) return (h >= MAX_H) ? MAX_H : h + 7'd1;
        else     return (h <= MIN_H) ? MIN_H : h - 7'd1;
    endfunction

    // Previous stepper phase, activity and disk-change levels for edge detection.
    always_ff @(posedge clk_c1541) begin
        stp_r <= stp;
        act_r <= act;
        dc_r  <= disk_change;
    end

    // Adjacent phase transitions are steps; anything else is treated as noise.
    always_comb begin
        stp_up   = stp_r + 2'd1;
        stp_dn   = stp_r - 2'd1;
        step_inc = mtr && (stp == stp_up);
        step_dec = mtr && (stp == stp_dn);
        step     = step_inc || step_dec;
        act_fall = act_r && !act;
        dc_fall  = dc_r && !disk_change;
    end

    assign tr00_sense_n = (half_track[6:1] != 6'd0);

    // State register.
    always_ff @(posedge clk_c1541) begin
        if (reset) state <= SETTLE;
        else       state <= state_nxt;
    end

    // Next-state decisions, loader requests and buffer-ready indication.
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        latch_track = 1'b0;
        set_valid   = 1'b0;
        save_acc    = 1'b0;
        flush_start = 1'b0;
        flush_end   = 1'b0;
        save_req    = 1'b0;
        load_req    = 1'b0;
        ready       = 1'b0;
        case (state)
            IDLE: begin
                ready = loaded_valid;
                if (step || dc_fall) begin
                    state_nxt = SETTLE;
                    cnt_clr   = 1'b1;
                end else if (ACT_FLUSH && act_fall && dirty && !disk_change) begin
                    state_nxt   = SAVE;
                    flush_start = 1'b1;
                end
            end
            SETTLE: begin
                // A flush is never decided while the image is being swapped.
                if (step || disk_change || dc_fall) begin
                    cnt_clr = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    if (loaded_valid && (track == half_track[6:1])) begin
                        state_nxt = IDLE;
                    end else if (dirty) begin
                        state_nxt = SAVE;
                    end else begin
                        state_nxt   = LOAD;
                        latch_track = 1'b1;
                    end
                end
            end
            SAVE: begin
                save_req = 1'b1;
                ready    = act_flush && loaded_valid && !flush_moved;
                if (busy) begin
                    save_acc  = 1'b1;
                    state_nxt = SAVE_WAIT;
                end
            end
            SAVE_WAIT: begin
                ready = act_flush && loaded_valid && !flush_moved;
                if (!busy) begin
                    if (act_flush) begin
                        // Activity flush keeps the buffer unless the head moved meanwhile.
                        flush_end = 1'b1;
                        if (flush_moved || step || !loaded_valid) begin
                            state_nxt = SETTLE;
                            cnt_clr   = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt   = LOAD;
                        latch_track = 1'b1;
                    end
                end
            end
            LOAD: begin
                load_req = 1'b1;
                if (busy) state_nxt = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (!busy) begin
                    set_valid = 1'b1;
                    state_nxt = SETTLE;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = SETTLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // Head position, committed track and settle counter.
    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            half_track <= RST_H;
            track      <= RST_TRACK;
            cnt        <= '0;
        end else begin
            if (step)
                half_track <= sat_step(half_track, step_inc);
            if (latch_track)
                track <= half_track[6:1];
            if (cnt_clr || step)
                cnt <= '0;
            else if (state == SETTLE && cnt != CNT_LAST)
                cnt <= cnt + 1'b1;
        end
    end

    // Buffer bookkeeping: dirty, valid contents and activity-flush tracking.
    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            dirty        <= 1'b0;
            loaded_valid <= 1'b0;
            dc_seen      <= 1'b0;
            act_flush    <= 1'b0;
            flush_moved  <= 1'b0;
        end else begin
            // A write during an activity flush belongs after the saved image.
            if (disk_change)
                dirty <= 1'b0;
            else if (buff_we && ((state == IDLE && ready) || act_flush))
                dirty <= 1'b1;
            else if (save_acc)
                dirty <= 1'b0;

            // A load overlapping a disk swap may carry the old image.
            if (disk_change)
                dc_seen <= 1'b1;
            else if (latch_track)
                dc_seen <= 1'b0;

            if (disk_change)
                loaded_valid <= 1'b0;
            else if (set_valid && !dc_seen)
                loaded_valid <= 1'b1;

            if (flush_start)
                act_flush <= 1'b1;
            else if (flush_end)
                act_flush <= 1'b0;

            if (flush_start)
                flush_moved <= 1'b0;
            else if (act_flush && step)
                flush_moved <= 1'b1;
        end
    end

endmodule

// File: tb/tb_c1541_track_sched.sv
// Testbench for c1541_track_sched: scenario tasks drive stepper, write and
// disk-change stimulus; expected loader requests go into a scoreboard queue and
// are compared when the DUT raises save_req or load_req.
module tb_c1541_track_sched;

    localparam int S = 200;

    logic       clk_c1541 = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] stp = 2'd0;
    logic       mtr = 1'b0;
    logic       act = 1'b0;
    logic       buff_we = 1'b0;
    logic       disk_change = 1'b0;
    logic       busy = 1'b0;
    logic [5:0] track;
    logic [6:0] half_track;
    logic       tr00_sense_n, save_req, load_req, ready, dirty;

    typedef struct packed {
        logic       is_save;
        logic [5:0] trk;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   auto_en = 1'b1;
    logic save_q = 1'b0, load_q = 1'b0;

    c1541_track_sched #(
        .SETTLE_CYC(S), .RESET_HALF(36), .MIN_HALF(1), .MAX_HALF(80)
    ) dut (
        .clk_c1541(clk_c1541), .reset(reset), .stp(stp), .mtr(mtr), .act(act),
        .buff_we(buff_we), .disk_change(disk_change), .busy(busy),
        .track(track), .half_track(half_track), .tr00_sense_n(tr00_sense_n),
        .save_req(save_req), .load_req(load_req), .ready(ready), .dirty(dirty)
    );

    always #5 clk_c1541 = ~clk_c1541;

    // Scoreboard: every rising request must match the next expected entry.
    always @(negedge clk_c1541) begin
        exp_t e;
        if (save_req && !save_q) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_save unexpected save_req track=%0d required no request", track);
            end else begin
                e = sb.pop_front();
                if (!e.is_save || track !== e.trk) begin
                    miscompares++;
                    $display("FAIL sb_save got save track=%0d required %s track=%0d",
                             track, e.is_save ? "save" : "load", e.trk);
                end
            end
        end
        if (load_req && !load_q) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_load unexpected load_req track=%0d required no request", track);
            end else begin
                e = sb.pop_front();
                if (e.is_save || track !== e.trk) begin
                    miscompares++;
                    $display("FAIL sb_load got load track=%0d required %s track=%0d",
                             track, e.is_save ? "save" : "load", e.trk);
                end
            end
        end
        save_q = save_req;
        load_q = load_req;
    end

    // Loader model: accept a request two cycles later and stay busy ten cycles.
    initial begin
        forever begin
            @(negedge clk_c1541);
            if (auto_en && (save_req || load_req) && !busy) begin
                repeat (2) @(negedge clk_c1541);
                busy = 1'b1;
                repeat (10) @(negedge clk_c1541);
                busy = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_c1541);
    endtask

    // Wait for a signal (0 load_req, 1 save_req, 2 ready) with a cycle bound.
    task automatic wait_sig(input int which, input int bound, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < bound && !seen) begin
            @(negedge clk_c1541);
            cyc++;
            case (which)
                0: seen = load_req;
                1: seen = save_req;
                default: seen = ready;
            endcase
        end
    endtask

    task automatic step_to(input logic [1:0] p);
        @(negedge clk_c1541);
        stp = p;
    endtask

    task automatic test_reset;
        int cyc; bit seen;
        reset = 1'b1;
        tick(3);
        vectors++;
        if (half_track !== 7'd36 || track !== 6'd18 || tr00_sense_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pos half=%0d track=%0d tr00_n=%b required 36 18 1",
                     half_track, track, tr00_sense_n);
        end
        vectors++;
        if ({save_req, load_req, ready, dirty} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags save/load/ready/dirty=%b required 0000",
                     {save_req, load_req, ready, dirty});
        end
        sb.push_back('{1'b0, 6'd18});
        reset = 1'b0;
        wait_sig(0, S + 20, cyc, seen);
        vectors++;
        if (!seen || cyc < S - 1 || cyc > S + 2) begin
            miscompares++;
            $display("FAIL reset_load_latency seen=%0d cycles=%0d required about %0d", seen, cyc, S);
        end
        wait_sig(2, 3 * S, cyc, seen);
        vectors++;
        if (ready !== 1'b1 || dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready ready=%b dirty=%b required 1 0", ready, dirty);
        end
    endtask

    task automatic test_step_inc;
        int cyc; bit seen;
        mtr = 1'b1;
        sb.push_back('{1'b0, 6'd20});
        step_to(2'd1);
        tick(2);
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL step_ready_drop ready=%b required 0", ready);
        end
        tick(98);
        step_to(2'd2);
        tick(99);
        step_to(2'd3);
        tick(99);
        step_to(2'd0);
        wait_sig(0, S + 20, cyc, seen);
        vectors++;
        if (!seen || cyc < S - 1 || cyc > S + 2) begin
            miscompares++;
            $display("FAIL step_load_latency seen=%0d cycles=%0d required about %0d", seen, cyc, S);
        end
        vectors++;
        if (half_track !== 7'd40) begin
            miscompares++;
            $display("FAIL step_half got %0d required 40", half_track);
        end
        wait_sig(2, 3 * S, cyc, seen);
        vectors++;
        if (ready !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL step_done ready=%b pending=%0d required 1 0", ready, sb.size());
        end
    endtask

    task automatic test_dirty_save;
        int cyc; bit seen;
        @(negedge clk_c1541); buff_we = 1'b1;
        @(negedge clk_c1541); buff_we = 1'b0;
        tick(1);
        vectors++;
        if (dirty !== 1'b1) begin
            miscompares++;
            $display("FAIL dirty_set got %b required 1", dirty);
        end
        sb.push_back('{1'b1, 6'd20});
        sb.push_back('{1'b0, 6'd21});
        step_to(2'd1);
        tick(9);
        step_to(2'd2);
        wait_sig(1, S + 20, cyc, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL dirty_save_seen got none required save_req");
        end
        wait_sig(0, 60, cyc, seen);
        vectors++;
        if (!seen || dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL dirty_after_save load_seen=%0d dirty=%b required 1 0", seen, dirty);
        end
        wait_sig(2, 3 * S, cyc, seen);
        vectors++;
        if (half_track !== 7'd42 || track !== 6'd21 || ready !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL dirty_done half=%0d track=%0d ready=%b pending=%0d required 42 21 1 0",
                     half_track, track, ready, sb.size());
        end
    endtask

    task automatic test_ignored_steps;
        mtr = 1'b0;
        step_to(2'd3);
        tick(5);
        vectors++;
        if (half_track !== 7'd42 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL motor_off_step half=%0d ready=%b required 42 1", half_track, ready);
        end
        mtr = 1'b1;
        step_to(2'd1);
        tick(5);
        vectors++;
        if (half_track !== 7'd42 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL skip_phase half=%0d ready=%b required 42 1", half_track, ready);
        end
    endtask

    task automatic test_saturate_min;
        int cyc; bit seen;
        logic [1:0] p;
        p = 2'd1;
        sb.push_back('{1'b0, 6'd0});
        for (int i = 0; i < 50; i++) begin
            p = p - 2'd1;
            step_to(p);
            tick(9);
        end
        vectors++;
        if (half_track !== 7'd1 || tr00_sense_n !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_min half=%0d tr00_n=%b required 1 0", half_track, tr00_sense_n);
        end
        wait_sig(0, S + 20, cyc, seen);
        wait_sig(2, 3 * S, cyc, seen);
        vectors++;
        if (track !== 6'd0 || ready !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL sat_min_load track=%0d ready=%b pending=%0d required 0 1 0",
                     track, ready, sb.size());
        end
    endtask

    task automatic test_disk_change;
        int cyc; bit seen;
        @(negedge clk_c1541); buff_we = 1'b1;
        @(negedge clk_c1541); buff_we = 1'b0;
        tick(1);
        vectors++;
        if (dirty !== 1'b1) begin
            miscompares++;
            $display("FAIL dc_dirty_set got %b required 1", dirty);
        end
        disk_change = 1'b1;
        tick(100);
        vectors++;
        if (dirty !== 1'b0 || ready !== 1'b0 || save_req !== 1'b0) begin
            miscompares++;
            $display("FAIL dc_hold dirty=%b ready=%b save=%b required 0 0 0",
                     dirty, ready, save_req);
        end
        sb.push_back('{1'b0, 6'd0});
        disk_change = 1'b0;
        wait_sig(0, S + 20, cyc, seen);
        vectors++;
        if (!seen || cyc < S - 1 || cyc > S + 2) begin
            miscompares++;
            $display("FAIL dc_load_latency seen=%0d cycles=%0d required about %0d", seen, cyc, S);
        end
        wait_sig(2, 3 * S, cyc, seen);
        vectors++;
        if (ready !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL dc_done ready=%b pending=%0d required 1 0", ready, sb.size());
        end
    endtask

    task automatic test_reset_mid_handshake;
        int cyc; bit seen;
        auto_en = 1'b0;
        sb.push_back('{1'b0, 6'd1});
        step_to(2'd0);
        wait_sig(0, S + 20, cyc, seen);
        tick(5);
        vectors++;
        if (load_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_hold load_req=%b required 1", load_req);
        end
        @(negedge clk_c1541); reset = 1'b1;
        @(negedge clk_c1541);
        vectors++;
        if (load_req !== 1'b0 || half_track !== 7'd36 || track !== 6'd18) begin
            miscompares++;
            $display("FAIL reset_mid load=%b half=%0d track=%0d required 0 36 18",
                     load_req, half_track, track);
        end
        sb.push_back('{1'b0, 6'd18});
        @(negedge clk_c1541); reset = 1'b0;
        auto_en = 1'b1;
        wait_sig(0, S + 20, cyc, seen);
        wait_sig(2, 3 * S, cyc, seen);
        vectors++;
        if (ready !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_done ready=%b pending=%0d required 1 0", ready, sb.size());
        end
    endtask

    task automatic test_act_flush;
        bit dropped;
        @(negedge clk_c1541); buff_we = 1'b1;
        @(negedge clk_c1541); buff_we = 1'b0;
        @(negedge clk_c1541); act = 1'b1;
        tick(3);
`ifdef C1541_ACT_FLUSH_EN
        sb.push_back('{1'b1, 6'd18});
`endif
        @(negedge clk_c1541); act = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_c1541);
            if (ready !== 1'b1) dropped = 1'b1;
        end
        vectors++;
        if (dropped || sb.size() != 0) begin
            miscompares++;
            $display("FAIL act_ready dropped=%0d pending=%0d required 0 0", dropped, sb.size());
        end
`ifdef C1541_ACT_FLUSH_EN
        vectors++;
        if (dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL act_dirty got %b required 0", dirty);
        end
`else
        vectors++;
        if (dirty !== 1'b1) begin
            miscompares++;
            $display("FAIL act_dirty got %b required 1", dirty);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_step_inc();
        test_dirty_save();
        test_ignored_steps();
        test_saturate_min();
        test_disk_change();
        test_reset_mid_handshake();
        test_act_flush();
        tick(20);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_empty pending=%0d required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
